alu_mul_seq: RTL and testbench

//  Multi-cycle 8x8 unsigned multiply sequencer built on the shared 8-bit ALU.

---
 rtl/alu_mul_seq.sv | 120 ++++++++++++
 tb/tb_alu_mul_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 unsigned shift-and-add multiplier.
// Borrows the shared ALU (ADD/LSR only) one op per cycle while busy.
module alu_mul_seq #(
  parameter logic [4:0] OP_ADD = 5'b00000,
  parameter logic [4:0] OP_LSR = 5'b00111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mcand,
  input  logic [7:0]  mplier,
  output logic        ready,
  output logic        done,
  output logic [15:0] product,
  output logic        alu_own,
  output logic [4:0]  alu_cmd,
  output logic [7:0]  alu_inA,
  output logic [7:0]  alu_inB,
  output logic        alu_sc_i,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_sc_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADD  = 3'd1;
  localparam logic [2:0] S_SHH  = 3'd2;
  localparam logic [2:0] S_SHL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state;
  logic [7:0] a_q;
  logic [7:0] ph;
  logic [7:0] pl;
  logic       c_q;
  logic       b_q;
  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      a_q   <= '0;
      ph    <= '0;
      pl    <= '0;
      c_q   <= 1'b0;
      b_q   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= mcand;
            ph    <= '0;
            pl    <= mplier;
            cnt   <= '0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          ph    <= alu_rslt;
          c_q   <= alu_sc_o;
          state <= S_SHH;
        end
        S_SHH: begin
          ph    <= alu_rslt;
          b_q   <= alu_sc_o;
          state <= S_SHL;
        end
        S_SHL: begin
          pl <= alu_rslt;
          if (cnt == 3'd7) begin
            state <= S_DONE;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= S_ADD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU steering decodes only registered state: no path from start.
  always_comb begin
    alu_cmd  = OP_ADD;
    alu_inA  = '0;
    alu_inB  = '0;
    alu_sc_i = 1'b0;
    unique case (state)
      S_ADD: begin
        alu_cmd = OP_ADD;
        alu_inA = ph;
        alu_inB = pl[0] ? a_q : 8'h00;
      end
      S_SHH: begin
        alu_cmd  = OP_LSR;
        alu_inA  = ph;
        alu_sc_i = c_q;
      end
      S_SHL: begin
        alu_cmd  = OP_LSR;
        alu_inA  = pl;
        alu_sc_i = b_q;
      end
      default: begin
        alu_cmd  = OP_ADD;
        alu_inA  = '0;
        alu_inB  = '0;
        alu_sc_i = 1'b0;
      end
    endcase
  end

  assign ready   = (state == S_IDLE);
  assign done    = (state == S_DONE);
  assign alu_own = (state == S_ADD) || (state == S_SHH) ||
                   (state == S_SHL);
  assign product = {ph, pl};

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed bench for alu_mul_seq.
// Includes a behavioural model of the shared ALU.
module tb_alu_mul_seq;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_LSR = 5'b00111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  mcand = '0;
  logic [7:0]  mplier = '0;
  logic        ready;
  logic        done;
  logic [15:0] product;
  logic        alu_own;
  logic [4:0]  alu_cmd;
  logic [7:0]  alu_inA;
  logic [7:0]  alu_inB;
  logic        alu_sc_i;
  logic [7:0]  alu_rslt;
  logic        alu_sc_o;

  int checks = 0;
  int failures = 0;
  int mode = 0;

  alu_mul_seq #(.OP_ADD(OP_ADD), .OP_LSR(OP_LSR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mcand(mcand), .mplier(mplier),
    .ready(ready), .done(done), .product(product),
    .alu_own(alu_own), .alu_cmd(alu_cmd),
    .alu_inA(alu_inA), .alu_inB(alu_inB),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
    .alu_sc_o(alu_sc_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_rslt = '0;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      OP_ADD: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB}
                                     + {8'h00, alu_sc_i};
      OP_LSR: {alu_rslt, alu_sc_o} = {alu_sc_i, alu_inA};
      default: begin
        alu_rslt = '0;
        alu_sc_o = 1'b0;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge with the DUT idle; returns at the done negedge.
  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp);
    int lat;
    logic seen;
    chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
    mcand = a;
    mplier = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mcand = 8'h5c;
    mplier = 8'hc5;
    lat = 0;
    seen = 1'b0;
    while (lat < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (mode == 2 && lat == 0)
        chk({tag, "_first_inB"}, {24'd0, alu_inB}, 32'hff);
      if (mode == 2 && lat == 23)
        chk({tag, "_last_sc_i"}, {31'd0, alu_sc_i}, 32'd0);
      if (mode == 3 && alu_own && alu_cmd == OP_ADD)
        chk({tag, "_add_inB"}, {24'd0, alu_inB}, 32'd0);
      @(posedge clk);
      lat++;
    end
    chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_lat"}, lat, 32'd24);
    chk({tag, "_prod"}, {16'd0, product}, {16'd0, exp});
  endtask

  initial begin
    int t[3];
    int nd;
    int cyc;
    logic rdy_ok;

    #2;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_own", {31'd0, alu_own}, 32'd0);
    chk("rst_prod", {16'd0, product}, 32'd0);
    chk("rst_cmd", {27'd0, alu_cmd}, {27'd0, OP_ADD});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("t1", 8'h0d, 8'h0b, 16'h008f);
    @(negedge clk);
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_ready_back", {31'd0, ready}, 32'd1);
    chk("t1_hold", {16'd0, product}, 32'h008f);

    mode = 2;
    run_op("t2", 8'hff, 8'hff, 16'hfe01);
    @(negedge clk);
    mode = 3;
    run_op("t3a", 8'h00, 8'ha5, 16'h0000);
    @(negedge clk);
    run_op("t3b", 8'h5a, 8'h00, 16'h0000);
    @(negedge clk);
    mode = 0;

    // Stray starts during the op and in its DONE cycle.
    mcand = 8'h10;
    mplier = 8'h10;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rdy_ok = 1'b1;
    cyc = 0;
    nd = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (ready) rdy_ok = 1'b0;
      start = 1'b0;
      if (cyc == 5 || cyc == 12 || done) begin
        mcand = 8'h02;
        mplier = 8'h03;
        start = 1'b1;
      end
      if (done) begin
        nd = cyc;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    chk("t4_lat", nd, 32'd24);
    chk("t4_ready_low", {31'd0, rdy_ok}, 32'd1);
    chk("t4_prod", {16'd0, product}, 32'h0100);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("t4_idle", {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t4_no_run", {31'd0, alu_own}, 32'd0);
    chk("t4_prod_kept", {16'd0, product}, 32'h0100);

    // Reset mid-op.
    mcand = 8'h33;
    mplier = 8'h44;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_ready", {31'd0, ready}, 32'd1);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_own", {31'd0, alu_own}, 32'd0);
    chk("t5_prod", {16'd0, product}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("t5b", 8'h07, 8'h06, 16'h002a);
    @(negedge clk);

    // start held high across three back-to-back ops.
    mcand = 8'h81;
    mplier = 8'h81;
    start = 1'b1;
    cyc = 0;
    nd = 0;
    while (cyc < 200 && nd < 3) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) begin
        t[nd] = cyc;
        nd++;
        chk("t6_prod", {16'd0, product}, 32'h4101);
      end
    end
    start = 1'b0;
    chk("t6_count", nd, 32'd3);
    if (nd == 3) begin
      chk("t6_first", t[0], 32'd25);
      chk("t6_gap1", t[1] - t[0], 32'd26);
      chk("t6_gap2", t[2] - t[1], 32'd26);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
